// File: rtl/wb_release_unit.sv
// wb_release_unit: drains one dirty-line writeback onto the outer C channel.
// Reads the line beat-by-beat from the data array and sends it as
// ReleaseData (voluntary) or ProbeAckData (probe response). After a
// ReleaseData line the unit stays busy until the ReleaseAck pulse.
//
// Ports:
//   clock, reset (async, active-low)
//   io_req_*      : writeback request in (valid/ready)
//   io_data_req_* : data-array read request out (valid/ready)
//   io_data_resp  : read data, one cycle after the read fires
//   io_rel_*      : C-channel beat out (valid/ready)
//   io_rel_ack_valid : ReleaseAck pulse in
//   io_busy       : unit not idle
//
// Optional feature macro: WB_RELEASE_ACK_TIMEOUT_EN
//   Adds io_ack_timeout, a one-cycle pulse raised when no ReleaseAck
//   arrives within TIMEOUT_CYC cycles; the unit then returns to idle.

module wb_release_unit #(
    parameter int BEATS       = 8,
    parameter int DATA_W      = 64,
    parameter int TAG_W       = 20,
    parameter int IDX_W       = 6,
    parameter int OFF_W       = 6,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         clock,
    input  logic                         reset,

    input  logic                         io_req_valid,
    output logic                         io_req_ready,
    input  logic [TAG_W-1:0]             io_req_bits_tag,
    input  logic [IDX_W-1:0]             io_req_bits_idx,
    input  logic [1:0]                   io_req_bits_source,
    input  logic [2:0]                   io_req_bits_param,
    input  logic                         io_req_bits_way_en,
    input  logic                         io_req_bits_voluntary,

    output logic                         io_data_req_valid,
    input  logic                         io_data_req_ready,
    output logic [IDX_W-1:0]             io_data_req_bits_idx,
    output logic                         io_data_req_bits_way_en,
    output logic [$clog2(BEATS)-1:0]     io_data_req_bits_beat,
    input  logic [DATA_W-1:0]            io_data_resp,

    output logic                         io_rel_valid,
    input  logic                         io_rel_ready,
    output logic [2:0]                   io_rel_bits_opcode,
    output logic [2:0]                   io_rel_bits_param,
    output logic [1:0]                   io_rel_bits_source,
    output logic [TAG_W+IDX_W+OFF_W-1:0] io_rel_bits_address,
    output logic [DATA_W-1:0]            io_rel_bits_data,

    input  logic                         io_rel_ack_valid,
`ifdef WB_RELEASE_ACK_TIMEOUT_EN
    output logic                         io_ack_timeout,
`endif
    output logic                         io_busy
);

    localparam int BEAT_W = $clog2(BEATS);

    localparam logic [2:0] OP_RELEASE_DATA  = 3'd7;
    localparam logic [2:0] OP_PROBEACK_DATA = 3'd5;

    if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0 || TIMEOUT_CYC < 1)
    begin : g_cfg_check
        $error("wb_release_unit: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_SEND,
        S_WAIT_ACK
    } state_t;

    state_t state;
    state_t state_nx;

    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        source_q;
    logic [2:0]        param_q;
    logic              way_en_q;
    logic              vol_q;
    logic [BEAT_W-1:0] beat_q;
    logic [DATA_W-1:0] buf_q;

    logic req_fire;
    logic rel_fire;
    logic last_beat;

    assign req_fire  = io_req_valid & io_req_ready;
    assign rel_fire  = io_rel_valid & io_rel_ready;
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

`ifdef WB_RELEASE_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             tmo_hit;

    // Counter sits at zero outside WAIT_ACK, so it is cleared on entry
    // and holds the number of cycles already spent waiting.
    assign tmo_hit = (state == S_WAIT_ACK) &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state != S_WAIT_ACK) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx          = state;
        io_req_ready      = 1'b0;
        io_data_req_valid = 1'b0;
        io_rel_valid      = 1'b0;
`ifdef WB_RELEASE_ACK_TIMEOUT_EN
        io_ack_timeout    = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                io_req_ready = 1'b1;
                if (io_req_valid) begin
                    state_nx = S_READ;
                end
            end
            S_READ: begin
                io_data_req_valid = 1'b1;
                if (io_data_req_ready) begin
                    state_nx = S_CAPT;
                end
            end
            S_CAPT: begin
                state_nx = S_SEND;
            end
            S_SEND: begin
                io_rel_valid = 1'b1;
                if (io_rel_ready) begin
                    if (!last_beat) begin
                        state_nx = S_READ;
                    end else if (vol_q) begin
                        state_nx = S_WAIT_ACK;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_WAIT_ACK: begin
                // A same-cycle ack takes priority over the timeout.
                if (io_rel_ack_valid) begin
                    state_nx = S_IDLE;
                end
`ifdef WB_RELEASE_ACK_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nx       = S_IDLE;
                    io_ack_timeout = 1'b1;
                end
`endif
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_q    <= '0;
            idx_q    <= '0;
            source_q <= '0;
            param_q  <= '0;
            way_en_q <= 1'b0;
            vol_q    <= 1'b0;
            beat_q   <= '0;
            buf_q    <= '0;
        end else begin
            if (req_fire) begin
                tag_q    <= io_req_bits_tag;
                idx_q    <= io_req_bits_idx;
                source_q <= io_req_bits_source;
                param_q  <= io_req_bits_param;
                way_en_q <= io_req_bits_way_en;
                vol_q    <= io_req_bits_voluntary;
                beat_q   <= '0;
            end
            if (state == S_CAPT) begin
                buf_q <= io_data_resp;
            end
            if (rel_fire) begin
                beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
            end
        end
    end

    assign io_data_req_bits_idx    = idx_q;
    assign io_data_req_bits_way_en = way_en_q;
    assign io_data_req_bits_beat   = beat_q;

    assign io_rel_bits_opcode  = vol_q ? OP_RELEASE_DATA : OP_PROBEACK_DATA;
    assign io_rel_bits_param   = param_q;
    assign io_rel_bits_source  = source_q;
    assign io_rel_bits_address = {tag_q, idx_q, {OFF_W{1'b0}}};
    assign io_rel_bits_data    = buf_q;

    assign io_busy = (state != S_IDLE);

endmodule
